// File: rtl/color_match_judge_if.sv
// color_match_judge_if: round-referee bus between the colour randomizer,
// the collision logic and the game-over/display logic.
//
// Handshake: there is no ready path. land_valid is a one-cycle pulse that is
// accepted only while the referee is ARMED (busy=1) and dropped otherwise.
// round_req, hit and miss are one-cycle pulses that the consumers must take
// on the cycle they are high. Everything else is a level.
//
// state_dbg encoding: 0 IDLE, 1 ARMED, 2 JUDGE, 3 OVER.
interface color_match_judge_if #(
    parameter int SCORE_W = 8
);
    logic               round_start;
    logic [11:0]        color_plats;
    logic [2:0]         color_ball;
    logic               land_valid;
    logic [1:0]         land_plat;
    logic               round_req;
    logic               hit;
    logic               miss;
    logic               busy;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               game_over;
    logic [2:0]         cur_ball_color;
    logic [1:0]         state_dbg;

    modport slave (
        input  round_start, color_plats, color_ball, land_valid, land_plat,
        output round_req, hit, miss, busy, score, lives, game_over,
               cur_ball_color, state_dbg
    );

    modport master (
        output round_start, color_plats, color_ball, land_valid, land_plat,
        input  round_req, hit, miss, busy, score, lives, game_over,
               cur_ball_color, state_dbg
    );
endinterface

// File: rtl/color_match_judge.sv
// color_match_judge: round referee for the colour-match game.
// Latches colours at round start, waits for the landing report, judges hit
// or miss, keeps score/lives and asks the randomizer for the next colours.
// Optional landing timeout is enabled by defining COLOR_MATCH_TIMEOUT_EN.
module color_match_judge #(
    parameter int          SCORE_W     = 8,
    parameter int          LIVES_INIT  = 3,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic                clk,
    input  logic                resetn,
    color_match_judge_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_JUDGE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [1:0]         LIVES_RST = 2'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t state_q, state_d;

    logic [11:0]        plats_q, plats_d;
    logic [2:0]         ball_q, ball_d;
    logic [1:0]         slot_q, slot_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               round_req_q, round_req_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;

    logic               round_ok;
    logic [2:0]         slot_color;
    logic               judge_hit;
    logic               timeout_now;
    logic               forced_miss;

    // A round is playable only with a real ball colour present on some slot.
    assign round_ok = (bus.color_ball != 3'b000) &&
                      ((bus.color_plats[2:0]  == bus.color_ball) ||
                       (bus.color_plats[5:3]  == bus.color_ball) ||
                       (bus.color_plats[8:6]  == bus.color_ball) ||
                       (bus.color_plats[11:9] == bus.color_ball));

    // Colour of the latched landing slot.
    always_comb begin
        slot_color = plats_q[2:0];
        case (slot_q)
            2'd0:    slot_color = plats_q[2:0];
            2'd1:    slot_color = plats_q[5:3];
            2'd2:    slot_color = plats_q[8:6];
            default: slot_color = plats_q[11:9];
        endcase
    end

    assign judge_hit = !forced_miss && (slot_color == ball_q);

`ifdef COLOR_MATCH_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] to_cnt_q;
    logic        forced_miss_q;

    // Landing timer: zero on ARMED entry, counts every ARMED cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (state_q != S_ARMED && state_d == S_ARMED) begin
            to_cnt_q <= '0;
        end else if (state_q == S_ARMED) begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    // A real landing on the last cycle beats the timeout.
    assign timeout_now = (state_q == S_ARMED) && !bus.land_valid &&
                         (to_cnt_q == TO_LAST);

    // Remember that the coming JUDGE cycle is a forced miss.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            forced_miss_q <= 1'b0;
        end else begin
            forced_miss_q <= timeout_now;
        end
    end

    assign forced_miss = forced_miss_q;
`else
    // Without the timer ARMED waits for the landing indefinitely.
    assign timeout_now = 1'b0;
    assign forced_miss = 1'b0;

    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.round_start && round_ok) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.land_valid || timeout_now) begin
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (!judge_hit && lives_q == 2'd1) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (bus.round_start) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Next values of latched colours, score, lives and output pulses.
    always_comb begin
        plats_d     = plats_q;
        ball_d      = ball_q;
        slot_d      = slot_q;
        score_d     = score_q;
        lives_d     = lives_q;
        round_req_d = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.round_start) begin
                    plats_d     = bus.color_plats;
                    ball_d      = bus.color_ball;
                    round_req_d = !round_ok;
                end
            end
            S_ARMED: begin
                if (bus.land_valid) begin
                    slot_d = bus.land_plat;
                end
            end
            S_JUDGE: begin
                if (judge_hit) begin
                    hit_d       = 1'b1;
                    round_req_d = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                end else begin
                    miss_d      = 1'b1;
                    lives_d     = lives_q - 2'd1;
                    round_req_d = (lives_q != 2'd1);
                end
            end
            default: begin
                if (bus.round_start) begin
                    score_d     = '0;
                    lives_d     = LIVES_RST;
                    round_req_d = 1'b1;
                end
            end
        endcase
        busy_d      = (state_d == S_ARMED);
        game_over_d = (state_d == S_OVER);
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plats_q     <= '0;
            ball_q      <= '0;
            slot_q      <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_RST;
            round_req_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            plats_q     <= plats_d;
            ball_q      <= ball_d;
            slot_q      <= slot_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            round_req_q <= round_req_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.round_req      = round_req_q;
    assign bus.hit            = hit_q;
    assign bus.miss           = miss_q;
    assign bus.busy           = busy_q;
    assign bus.score          = score_q;
    assign bus.lives          = lives_q;
    assign bus.game_over      = game_over_q;
    assign bus.cur_ball_color = ball_q;
    assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_color_match_judge.sv
// tb_color_match_judge: self-checking bench for color_match_judge.
// dut_a runs with LIVES_INIT=3, dut_b with LIVES_INIT=1; both share stimulus.
// Build with COLOR_MATCH_TIMEOUT_EN defined to also exercise the timeout.
module tb_color_match_judge;

    localparam logic [1:0] ST_IDLE = 2'd0;

    logic clk;
    logic resetn;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_score;
    logic [1:0]  m_lives;
    logic [12:0] exp_q[$];

    color_match_judge_if #(.SCORE_W(8)) ifa ();
    color_match_judge_if #(.SCORE_W(8)) ifb ();

    assign ifb.round_start = ifa.round_start;
    assign ifb.color_plats = ifa.color_plats;
    assign ifb.color_ball  = ifa.color_ball;
    assign ifb.land_valid  = ifa.land_valid;
    assign ifb.land_plat   = ifa.land_plat;

    color_match_judge #(.SCORE_W(8), .LIVES_INIT(3), .TIMEOUT_CYC(10)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa.slave)
    );

    color_match_judge #(.SCORE_W(8), .LIVES_INIT(1), .TIMEOUT_CYC(10)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, applied=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn          = 1'b0;
        ifa.round_start = 1'b0;
        ifa.color_plats = '0;
        ifa.color_ball  = '0;
        ifa.land_valid  = 1'b0;
        ifa.land_plat   = '0;
        exp_q.delete();
        m_score = 8'd0;
        m_lives = 2'd3;
        tick();
        tick();
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        tick();
    endtask

    // Plays one valid round on (plats, ball), landing on slot; checks timing.
    task automatic play_round(input logic [11:0] plats, input logic [2:0] ball,
                              input logic [1:0] slot);
        logic [11:0] sh;
        logic        eh;
        ifa.color_plats = plats;
        ifa.color_ball  = ball;
        ifa.round_start = 1'b1;
        tick();
        ifa.round_start = 1'b0;
        n_vec++;
        if ({ifa.busy, ifa.cur_ball_color} !== {1'b1, ball}) begin
            n_err++;
            $display("FAIL armed: busy/ball=%b/%0d required 1/%0d", ifa.busy, ifa.cur_ball_color, ball);
        end
        sh = plats >> (3 * slot);
        eh = (sh[2:0] == ball);
        if (eh) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
        end else begin
            m_lives = m_lives - 2'd1;
        end
        exp_q.push_back({eh, !eh, (eh || m_lives != 2'd0), m_score, m_lives});
        ifa.land_valid = 1'b1;
        ifa.land_plat  = slot;
        tick();
        ifa.land_valid = 1'b0;
        n_vec++;
        if ({ifa.hit, ifa.miss, ifa.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL judge_cycle: hit/miss/busy=%b required 000", {ifa.hit, ifa.miss, ifa.busy});
        end
        tick();
        n_vec++;
        if ({ifa.hit, ifa.miss} !== {eh, !eh}) begin
            n_err++;
            $display("FAIL verdict: hit/miss=%b required %b", {ifa.hit, ifa.miss}, {eh, !eh});
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (resetn && (ifa.hit || ifa.miss || ifa.round_req)) begin
            logic [12:0] obs;
            logic [12:0] exp;
            obs = {ifa.hit, ifa.miss, ifa.round_req, ifa.score, ifa.lives};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL event_unexpected: got %h required no event", obs);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL event: got %h required %h", obs, exp);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({ifa.round_req, ifa.hit, ifa.miss, ifa.busy, ifa.game_over, ifa.cur_ball_color,
             ifa.score, ifa.lives, ifa.state_dbg} !== {5'b0, 3'd0, 8'd0, 2'd3, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_a: outputs=%h", {ifa.round_req, ifa.hit, ifa.miss, ifa.busy,
                     ifa.game_over, ifa.cur_ball_color, ifa.score, ifa.lives});
        end
        n_vec++;
        if (ifb.lives !== 2'd1) begin
            n_err++;
            $display("FAIL reset_b_lives: got %0d required 1", ifb.lives);
        end
        release_reset();
    endtask

    task automatic test_hit_miss();
        play_round(12'o1234, 3'd3, 2'd1);
        play_round(12'o1234, 3'd3, 2'd2);
        n_vec++;
        if ({ifa.score, ifa.lives} !== {8'd1, 2'd2}) begin
            n_err++;
            $display("FAIL hit_miss_totals: score/lives=%0d/%0d required 1/2", ifa.score, ifa.lives);
        end
    endtask

    task automatic test_duplicates();
        play_round(12'o3303, 3'd3, 2'd2);
        play_round(12'o3303, 3'd3, 2'd1);
        play_round(12'o3303, 3'd3, 2'd3);
    endtask

    task automatic test_reroll();
        logic [11:0] plats_t[3] = '{12'o1234, 12'o1234, 12'o1230};
        logic [2:0]  ball_t[3]  = '{3'd0, 3'd7, 3'd0};
        for (int i = 0; i < 3; i++) begin
            ifa.color_plats = plats_t[i];
            ifa.color_ball  = ball_t[i];
            ifa.round_start = 1'b1;
            exp_q.push_back({1'b0, 1'b0, 1'b1, m_score, m_lives});
            tick();
            ifa.round_start = 1'b0;
            n_vec++;
            if ({ifa.round_req, ifa.busy, ifa.state_dbg, ifa.cur_ball_color} !==
                {1'b1, 1'b0, ST_IDLE, ball_t[i]}) begin
                n_err++;
                $display("FAIL reroll_%0d: req/busy/state/ball=%b/%b/%0d/%0d required 1/0/0/%0d",
                         i, ifa.round_req, ifa.busy, ifa.state_dbg, ifa.cur_ball_color, ball_t[i]);
            end
            tick();
            n_vec++;
            if (ifa.round_req !== 1'b0) begin
                n_err++;
                $display("FAIL reroll_width_%0d: round_req=%b required 0", i, ifa.round_req);
            end
        end
    endtask

    task automatic test_land_in_idle();
        ifa.land_valid = 1'b1;
        ifa.land_plat  = 2'($urandom_range(0, 3));
        tick();
        ifa.land_valid = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({ifa.busy, ifa.state_dbg} !== {1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL land_idle: busy/state=%b/%0d required 0/0", ifa.busy, ifa.state_dbg);
        end
    endtask

    task automatic test_armed_ignores();
        ifa.color_plats = 12'o1234;
        ifa.color_ball  = 3'd3;
        ifa.round_start = 1'b1;
        tick();
        ifa.color_plats = 12'o4444;
        ifa.color_ball  = 3'd4;
        repeat (3) tick();
        ifa.round_start = 1'b0;
        n_vec++;
        if ({ifa.busy, ifa.cur_ball_color} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL armed_ignore: busy/ball=%b/%0d required 1/3", ifa.busy, ifa.cur_ball_color);
        end
        m_lives = m_lives - 2'd1;
        exp_q.push_back({1'b0, 1'b1, 1'b1, m_score, m_lives});
        ifa.land_valid = 1'b1;
        ifa.land_plat  = 2'd0;
        tick();
        ifa.land_valid = 1'b0;
        tick();
        n_vec++;
        if (ifa.miss !== 1'b1) begin
            n_err++;
            $display("FAIL armed_ignore_verdict: miss=%b required 1", ifa.miss);
        end
    endtask

    task automatic test_game_over();
        play_round(12'o1234, 3'd3, 2'd2);
        n_vec++;
        if ({ifb.miss, ifb.round_req, ifb.lives, ifb.game_over} !== {1'b1, 1'b0, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL over_enter: miss/req/lives/over=%b/%b/%0d/%b required 1/0/0/1",
                     ifb.miss, ifb.round_req, ifb.lives, ifb.game_over);
        end
        ifa.land_valid = 1'b1;
        tick();
        ifa.land_valid = 1'b0;
        tick();
        n_vec++;
        if ({ifb.game_over, ifb.miss, ifb.round_req} !== 3'b100) begin
            n_err++;
            $display("FAIL over_hold: over/miss/req=%b required 100", {ifb.game_over, ifb.miss, ifb.round_req});
        end
        ifa.color_plats = 12'o5555;
        ifa.color_ball  = 3'd5;
        ifa.round_start = 1'b1;
        tick();
        ifa.round_start = 1'b0;
        n_vec++;
        if ({ifb.round_req, ifb.score, ifb.lives, ifb.game_over, ifb.busy, ifb.state_dbg,
             ifb.cur_ball_color} !== {1'b1, 8'd0, 2'd1, 1'b0, 1'b0, ST_IDLE, 3'd3}) begin
            n_err++;
            $display("FAIL restart: req/score/lives/over/busy/state/ball=%b/%0d/%0d/%b/%b/%0d/%0d required 1/0/1/0/0/0/3",
                     ifb.round_req, ifb.score, ifb.lives, ifb.game_over, ifb.busy, ifb.state_dbg,
                     ifb.cur_ball_color);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            play_round(12'o1234, 3'd3, 2'd1);
        end
        n_vec++;
        if ({ifa.score, ifa.lives} !== {8'd255, 2'd3}) begin
            n_err++;
            $display("FAIL saturate: score/lives=%0d/%0d required 255/3", ifa.score, ifa.lives);
        end
    endtask

    task automatic test_reset_armed();
        ifa.color_plats = 12'o1234;
        ifa.color_ball  = 3'd3;
        ifa.round_start = 1'b1;
        tick();
        ifa.round_start = 1'b0;
        ifa.land_valid  = 1'b1;
        ifa.land_plat   = 2'd1;
        #2;
        apply_reset();
        n_vec++;
        if ({ifa.round_req, ifa.hit, ifa.miss, ifa.busy, ifa.game_over, ifa.cur_ball_color,
             ifa.score, ifa.lives} !== {5'b0, 3'd0, 8'd0, 2'd3}) begin
            n_err++;
            $display("FAIL reset_armed: outputs=%h", {ifa.round_req, ifa.hit, ifa.miss, ifa.busy,
                     ifa.game_over, ifa.cur_ball_color, ifa.score, ifa.lives});
        end
        release_reset();
    endtask

`ifdef COLOR_MATCH_TIMEOUT_EN
    task automatic test_timeout(input logic land_late);
        ifa.color_plats = 12'o1234;
        ifa.color_ball  = 3'd3;
        ifa.round_start = 1'b1;
        tick();
        ifa.round_start = 1'b0;
        repeat (9) tick();
        n_vec++;
        if (ifa.busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_wait: busy=%b required 1", ifa.busy);
        end
        if (land_late) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
            exp_q.push_back({1'b1, 1'b0, 1'b1, m_score, m_lives});
            ifa.land_valid = 1'b1;
            ifa.land_plat  = 2'd1;
        end else begin
            m_lives = m_lives - 2'd1;
            exp_q.push_back({1'b0, 1'b1, 1'b1, m_score, m_lives});
        end
        tick();
        ifa.land_valid = 1'b0;
        n_vec++;
        if ({ifa.busy, ifa.hit, ifa.miss} !== 3'b000) begin
            n_err++;
            $display("FAIL timeout_judge: busy/hit/miss=%b required 000", {ifa.busy, ifa.hit, ifa.miss});
        end
        tick();
        n_vec++;
        if ({ifa.hit, ifa.miss} !== {land_late, !land_late}) begin
            n_err++;
            $display("FAIL timeout_verdict: hit/miss=%b required %b", {ifa.hit, ifa.miss}, {land_late, !land_late});
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_hit_miss();
        test_reroll();
        test_land_in_idle();
        apply_reset();
        release_reset();
        test_duplicates();
        apply_reset();
        release_reset();
        test_armed_ignores();
        apply_reset();
        release_reset();
        test_game_over();
        apply_reset();
        release_reset();
        test_saturation();
        test_reset_armed();
`ifdef COLOR_MATCH_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        tick();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL events_missing: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/color_match_judge.md
# color_match_judge

Round referee for the colour-match game. It latches the platform colour word and ball colour produced by the colour randomizer at round start, then waits for the physics/collision logic to report which platform slot the ball landed on. It judges hit or miss, keeps score and lives, and pulses a request back to the randomizer for the next round's colours. It sits between the randomizer (producer of colours) and the game-over/display logic (consumer of score, lives and verdict pulses).

## Interface
Parameters:
- SCORE_W, 8, score counter width
- LIVES_INIT, 3, lives loaded at reset/restart; legal 1..3
- TIMEOUT_CYC, 50000000, landing timeout in cycles; used only with the macro defined

Ports:
- clk  in  1  system clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- round_start  in  1  level sampled per cycle; request to begin a round or to restart after game over
- color_plats  in  12  four 3-bit platform colours; slot k at bits [3k+2:3k]
- color_ball  in  3  ball colour; 3'b000 (black) is invalid
- land_valid  in  1  one-cycle pulse: ball has landed
- land_plat  in  2  slot index landed on; valid with land_valid
- round_req  out  1  one-cycle pulse: randomizer must supply fresh colours
- hit  out  1  one-cycle pulse: landed slot colour equals ball colour
- miss  out  1  one-cycle pulse: mismatch or timeout
- busy  out  1  high while in ARMED
- score  out  SCORE_W  hits this game, saturating
- lives  out  2  remaining lives
- game_over  out  1  high in OVER
- cur_ball_color  out  3  latched ball colour for the renderer

## Operation
- States: IDLE, ARMED, JUDGE, OVER. Reset enters IDLE.
- Reset values: all pulses 0, busy 0, score 0, lives LIVES_INIT, game_over 0, cur_ball_color 0, latched plats 0.
- IDLE, round_start=1:
  - Latch color_plats and color_ball.
  - Round is valid if ball != 000 and at least one slot equals ball. Valid -> ARMED.
  - Invalid -> stay IDLE, pulse round_req (reroll); score and lives unchanged.
- ARMED: busy=1; round_start ignored; land_valid=1 -> latch land_plat, go JUDGE.
- JUDGE (exactly one cycle): compare latched slot[land_plat] with latched ball.
  - Equal: hit pulse, score+1 (holds at 2^SCORE_W-1), round_req pulse, -> IDLE.
  - Unequal: miss pulse, lives-1. If the new lives value is 0 -> OVER with no round_req; else round_req pulse, -> IDLE.
- OVER: game_over=1, all inputs ignored except round_start. round_start=1 -> score 0, lives LIVES_INIT, round_req pulse, -> IDLE; colours are not latched that cycle.
- Duplicate colours across slots are legal; any matching slot is a hit.
- Inputs land_valid in IDLE/JUDGE/OVER are dropped.

## Timing
- All outputs registered.
- land_valid sampled at edge E -> JUDGE after E. hit/miss, score, lives, round_req and state all update at E+1. Each pulse is exactly one cycle wide.
- Reroll: round_start sampled at edge E with invalid colours -> round_req high for the cycle after E.
- cur_ball_color updates at the latching edge.
- resetn low mid-round aborts immediately to the reset values; no pulse is emitted.

## Configuration
- COLOR_MATCH_TIMEOUT_EN defined:
  - A cycle counter clears on ARMED entry and increments each ARMED cycle.
  - When it reaches TIMEOUT_CYC-1 without land_valid, go to JUDGE as a forced miss, handled like any miss.
  - If land_valid coincides with the timeout cycle, land_valid wins and the landing is judged normally.
- Undefined: no counter logic; ARMED waits indefinitely; TIMEOUT_CYC is unused.

## Test plan
- Reset, plats=12'o1234 (slot0=4, slot3=1), ball=3, round_start, land_plat=1 -> hit pulse 2 edges after land_valid, score=1, lives=3, round_req pulse.
- Same colours, land_plat=2 -> miss, lives=2, score unchanged, round_req pulse.
- ball=000, then ball=7 with no slot=7 -> each gives a reroll round_req pulse, stays IDLE, busy=0.
- LIVES_INIT=1, one miss -> game_over=1, no round_req. Then round_start -> score 0, lives 1, round_req pulse, IDLE.
- Score at 255 with SCORE_W=8, hit -> score stays 255, hit still pulses. resetn dropped in ARMED -> all outputs at reset values on the next cycle.
- With macro, TIMEOUT_CYC=10, no land_valid -> miss pulse, lives-1. Repeat with land_valid on the 10th ARMED cycle -> judged normally.
